button_stepper: RTL and testbench

//  Conditions the raw push-button feeding the note sequencer. 2-FF synchronizer,

---
 rtl/button_stepper.sv | 189 ++++++++++++++++++
 tb/tb_button_stepper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_stepper.sv
// -----------------------------------------------------------------------------
// button_stepper
//   Conditions the raw push-button that feeds the note sequencer. The pin goes
//   through a 2-FF synchronizer, then a debounce / auto-repeat FSM. The FSM
//   emits single-cycle step pulses in the clk domain. The sequencer's select
//   counter advances one note per step_p.
//
// Parameters
//   DEBOUNCE_CYC   cycles the raw level must persist before a change is accepted (>=2)
//   REPEAT_DELAY   hold time after an accepted press before the first repeat
//   REPEAT_PERIOD  hold time between later repeats
//   ACTIVE_HIGH    1: btn_in high = pressed, 0: btn_in low = pressed
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   btn_in     in   raw asynchronous button pin
//   btn_state  out  debounced level, 1 = pressed
//   press_p    out  1-cycle pulse on an accepted press
//   repeat_p   out  1-cycle pulse on each auto-repeat
//   step_p     out  press_p | repeat_p
//   release_p  out  1-cycle pulse on an accepted release (optional, see below)
//
// Build option
//   BUTTON_STEPPER_RELEASE_PULSE_EN
//     When defined, release_p pulses when a release is accepted.
//     When undefined, release_p is tied to 0.
// -----------------------------------------------------------------------------
module button_stepper #(
   parameter int DEBOUNCE_CYC  = 240000,
   parameter int REPEAT_DELAY  = 6000000,
   parameter int REPEAT_PERIOD = 3000000,
   parameter bit ACTIVE_HIGH   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_state,
   output logic press_p,
   output logic repeat_p,
   output logic step_p,
   output logic release_p
);

   localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
   localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   // The debounce compare ends DEB_TC + 1 cycles after entry. Together with
   // the IDLE entry edge, this gives DEBOUNCE_CYC+2 edges of pin-to-pulse
   // latency. The repeat states count one extra cycle so repeats are spaced
   // REPEAT_DELAY+1 / REPEAT_PERIOD+1 edges apart.
   localparam logic [CW-1:0] DEB_TC    = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] DELAY_TC  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] PERIOD_TC = CW'(REPEAT_PERIOD);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      HELD_DELAY,
      HELD_REPEAT,
      DEB_RELEASE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          s1, s2;
   logic          raw;
   logic          btn_state_nxt, press_nxt, repeat_nxt;

   assign raw = ACTIVE_HIGH ? s2 : ~s2;

   // State register, synchronizer and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         btn_state <= 1'b0;
         press_p   <= 1'b0;
         repeat_p  <= 1'b0;
         step_p    <= 1'b0;
      end else begin
         s1        <= btn_in;
         s2        <= s1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_state <= btn_state_nxt;
         press_p   <= press_nxt;
         repeat_p  <= repeat_nxt;
         step_p    <= press_nxt | repeat_nxt;
      end
   end

   // Next-state and counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (raw) begin
               state_nxt = DEB_PRESS;
               cnt_nxt   = '0;
            end
         end
         DEB_PRESS: begin
            if (!raw) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DEB_TC) begin
               state_nxt = HELD_DELAY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HELD_DELAY: begin
            if (!raw) begin
               state_nxt = DEB_RELEASE;
               cnt_nxt   = '0;
            end else if (cnt == DELAY_TC) begin
               state_nxt = HELD_REPEAT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HELD_REPEAT: begin
            if (!raw) begin
               state_nxt = DEB_RELEASE;
               cnt_nxt   = '0;
            end else if (cnt == PERIOD_TC) begin
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DEB_RELEASE: begin
            // A bounce back to pressed is not a new press. It only restarts
            // the repeat delay.
            if (raw) begin
               state_nxt = HELD_DELAY;
               cnt_nxt   = '0;
            end else if (cnt == DEB_TC) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode. These values are registered on the same edge as the
   // transition that produces them.
   always_comb begin
      press_nxt     = (state == DEB_PRESS) && (state_nxt == HELD_DELAY);
      repeat_nxt    = ((state == HELD_DELAY) && (state_nxt == HELD_REPEAT)) ||
                      ((state == HELD_REPEAT) && raw && (cnt == PERIOD_TC));
      // The debounced level stays pressed while a release is still being
      // debounced.
      btn_state_nxt = (state_nxt == HELD_DELAY) || (state_nxt == HELD_REPEAT) ||
                      (state_nxt == DEB_RELEASE);
   end

`ifdef BUTTON_STEPPER_RELEASE_PULSE_EN
   logic release_nxt;

   always_comb begin
      release_nxt = (state == DEB_RELEASE) && (state_nxt == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         release_p <= 1'b0;
      end else begin
         release_p <= release_nxt;
      end
   end
`else
   assign release_p = 1'b0;
`endif

endmodule

// File: tb/tb_button_stepper.sv
// Bench for button_stepper with DEBOUNCE_CYC=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5, ACTIVE_HIGH=1.
//
// The reference model works on run lengths of the synchronized level. A
// level change is accepted after DEBOUNCE_CYC+1 consecutive edges that
// disagree with the current level. Repeats fall at hold counts of
// REPEAT_DELAY+1 + k*(REPEAT_PERIOD+1). The hold count is measured from the
// accepted press, or from the edge where a release bounce ends.
module tb_button_stepper;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic btn_in = 1'b0;
   logic btn_state, press_p, repeat_p, step_p, release_p;

   button_stepper #(
      .DEBOUNCE_CYC (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP),
      .ACTIVE_HIGH  (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .btn_state(btn_state),
      .press_p  (press_p),
      .repeat_p (repeat_p),
      .step_p   (step_p),
      .release_p(release_p)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_p1 = 0, m_p2 = 0, m_level = 0;
   bit m_press = 0, m_rep = 0, m_rel = 0;
   int m_run = 0, m_h = 0;

   always @(posedge clk or negedge rst_n) begin
      bit raw_now;
      if (!rst_n) begin
         m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_h = 0;
         m_press = 0; m_rep = 0; m_rel = 0;
      end else begin
         raw_now = m_p2;
         m_p2 = m_p1;
         m_p1 = btn_in;
         m_press = 0; m_rep = 0; m_rel = 0;
         if (!m_level) begin
            m_run = raw_now ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
               m_level = 1; m_run = 0; m_h = 0; m_press = 1;
            end
         end else if (!raw_now) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_level = 0; m_run = 0; m_rel = 1;
            end
         end else if (m_run > 0) begin
            m_run = 0; m_h = 0;
         end else begin
            m_h++;
            if (m_h >= RD + 1 && ((m_h - (RD + 1)) % (RP + 1)) == 0) m_rep = 1;
         end
      end
   end

   // ---------------- edge counter and pulse recording ----------------
   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int press_q[$], rep_q[$], step_q[$], fall_q[$], rel_q[$];
   bit prev_state = 0;
   bit cmp_en = 0;

   always @(negedge clk) begin
      int exp_rel;
      if (cmp_en) begin
`ifdef BUTTON_STEPPER_RELEASE_PULSE_EN
         exp_rel = int'(m_rel);
`else
         exp_rel = 0;
`endif
         chk("btn_state", int'(btn_state), int'(m_level));
         chk("press_p",   int'(press_p),   int'(m_press));
         chk("repeat_p",  int'(repeat_p),  int'(m_rep));
         chk("step_p",    int'(step_p),    int'(m_press | m_rep));
         chk("release_p", int'(release_p), exp_rel);
         if (press_p)   press_q.push_back(ecnt);
         if (repeat_p)  rep_q.push_back(ecnt);
         if (step_p)    step_q.push_back(ecnt);
         if (release_p) rel_q.push_back(ecnt);
         if (prev_state && !btn_state) fall_q.push_back(ecnt);
         prev_state = btn_state;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      press_q.delete(); rep_q.delete(); step_q.delete();
      fall_q.delete(); rel_q.delete();
   endtask

   // Compare recorded pulse edges, relative to the edge after 'base', with
   // hand-computed edge numbers.
   task automatic chk_q(input string name, input int q[$], input int base, input int e[$]);
      chk({name, "_count"}, q.size(), e.size());
      for (int i = 0; i < e.size(); i++)
         if (i < q.size()) chk({name, "_edge"}, q[i] - base - 1, e[i]);
   endtask

   initial begin
      int base;
      int none[$];
      int e[$];
      none = {};

      // Reset
      #2 rst_n = 1'b0;
      cmp_en = 1'b1;
      #2;
      chk("reset_btn_state", int'(btn_state), 0);
      chk("reset_step_p", int'(step_p), 0);
      @(posedge clk); #1;
      tick(2);
      rst_n = 1'b1;

      // 1: 8-cycle press. One press at edge 6. Release edge 8 makes btn_state
      //    fall at edge 14.
      clear_q(); base = ecnt;
      btn_in = 1'b1; tick(8);
      btn_in = 1'b0; tick(14);
      e = {6};  chk_q("t1_press", press_q, base, e);
      chk_q("t1_step", step_q, base, e);
      chk_q("t1_repeat", rep_q, base, none);
      e = {14}; chk_q("t1_fall", fall_q, base, e);
`ifdef BUTTON_STEPPER_RELEASE_PULSE_EN
      chk_q("t1_release", rel_q, base, e);
`else
      chk_q("t1_release", rel_q, base, none);
`endif

      // 2: 3-cycle blip is rejected.
      clear_q(); base = ecnt;
      btn_in = 1'b1; tick(3);
      btn_in = 1'b0; tick(10);
      chk_q("t2_press", press_q, base, none);
      chk_q("t2_fall", fall_q, base, none);
      chk("t2_btn_state", int'(btn_state), 0);

      // 3: 40-cycle hold. Press at 6, repeats at 17 + 6k through edge 41.
      clear_q(); base = ecnt;
      btn_in = 1'b1; tick(40);
      btn_in = 1'b0; tick(16);
      e = {6};                  chk_q("t3_press", press_q, base, e);
      e = {17, 23, 29, 35, 41}; chk_q("t3_repeat", rep_q, base, e);
      e = {6, 17, 23, 29, 35, 41}; chk_q("t3_step", step_q, base, e);
      e = {46};                 chk_q("t3_fall", fall_q, base, e);

      // 4: Low glitch on pin edges 12-13. The synchronized level is low on
      //    edges 14-15 and is pressed again at edge 16, so the first repeat
      //    moves to 16+11 = 27.
      clear_q(); base = ecnt;
      btn_in = 1'b1; tick(12);
      btn_in = 1'b0; tick(2);
      btn_in = 1'b1; tick(16);
      btn_in = 1'b0; tick(14);
      e = {6};  chk_q("t4_press", press_q, base, e);
      e = {27}; chk_q("t4_repeat", rep_q, base, e);
      e = {36}; chk_q("t4_fall", fall_q, base, e);

      // 5: Reset mid-hold. A fresh press comes 6 edges after reset release.
      clear_q(); base = ecnt;
      btn_in = 1'b1; tick(20);
      rst_n = 1'b0;
      #3;
      chk("t5_rst_btn_state", int'(btn_state), 0);
      chk("t5_rst_repeat_p", int'(repeat_p), 0);
      tick(2);
      clear_q(); base = ecnt;
      rst_n = 1'b1;
      tick(10);
      btn_in = 1'b0; tick(14);
      e = {6};  chk_q("t5_press", press_q, base, e);
      e = {16}; chk_q("t5_fall", fall_q, base, e);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
